// File: rtl/microcode_sequencer_pkg.sv
// +--------------------------------------------------------------------+
// | microcode_sequencer_pkg                                            |
// | Control-word field positions and boot-state encoding.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package microcode_sequencer_pkg;

  // Control word is organised as byte-wide planes.
  localparam int PLANE_W    = 8;
  localparam int MISC_PLANE = 1;
  localparam int SEQ_PLANE  = 2;

  localparam int DEF_RESET_UOP_BIT   = MISC_PLANE * PLANE_W + 7;
  localparam int DEF_OPCODE_SRC_BIT  = SEQ_PLANE * PLANE_W + 6;
  localparam int DEF_LOAD_OPCODE_BIT = SEQ_PLANE * PLANE_W + 7;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } boot_state_e;

endpackage

`default_nettype wire

// File: rtl/microcode_sequencer_store.sv
// +--------------------------------------------------------------------+
// | microcode_sequencer_store                                          |
// | Single-port control store: synchronous write, asynchronous read.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module microcode_sequencer_store
  import microcode_sequencer_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

`default_nettype wire

// File: rtl/microcode_sequencer.sv
// +--------------------------------------------------------------------+
// | microcode_sequencer                                                |
// | Bootstrapped writable control store with opcode/micro-op sequencing.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module microcode_sequencer
  import microcode_sequencer_pkg::*;
#(
  parameter int                OPCODE_W        = 6,
  parameter int                UOP_W           = 5,
  parameter int                CTRL_W          = 32,
  parameter logic [OPCODE_W-1:0] RESET_OPCODE  = '0,
  parameter int                RESET_UOP_BIT   = DEF_RESET_UOP_BIT,
  parameter int                LOAD_OPCODE_BIT = DEF_LOAD_OPCODE_BIT,
  parameter int                OPCODE_SRC_BIT  = DEF_OPCODE_SRC_BIT
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      hold,
  input  logic [OPCODE_W-1:0]       opword_opcode,
  input  logic [OPCODE_W-1:0]       bus_opcode,
  output logic [CTRL_W-1:0]         ctrl,
  output logic [OPCODE_W-1:0]       opcode,
  output logic [UOP_W-1:0]          uop_count,
  output logic                      fault,
  input  logic [7:0]                boot_data,
  input  logic                      boot_valid,
  input  logic                      boot_end,
  output logic [OPCODE_W+UOP_W-1:0] boot_addr,
  output logic                      n_booted
);

  localparam int AW    = OPCODE_W + UOP_W;
  localparam int DEPTH = 1 << AW;
  localparam int BYTES = CTRL_W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [UOP_W-1:0] UOP_MAX   = '1;
  localparam logic [AW-1:0]    ADDR_MAX  = '1;
  localparam logic [BCW-1:0]   LAST_BYTE = BCW'(BYTES - 1);

  boot_state_e       state, state_next;
  logic [BCW-1:0]    byte_cnt;
  logic [CTRL_W-1:0] asm_word;
  logic [CTRL_W-1:0] asm_next;
  logic              word_done;
  logic [AW-1:0]     store_addr;
  logic [CTRL_W-1:0] store_rdata;

  // Bytes arrive MSB first, so each new byte lands in the low lane.
  assign asm_next   = CTRL_W'({asm_word, boot_data});
  assign word_done  = (state == LOAD) && boot_valid && (byte_cnt == LAST_BYTE);
  assign store_addr = (state == LOAD) ? boot_addr : {opcode, uop_count};
  assign ctrl       = (state == RUN) ? store_rdata : '0;
  assign n_booted   = (state == LOAD);

  microcode_sequencer_store #(
    .DEPTH (DEPTH),
    .WIDTH (CTRL_W)
  ) u_store (
    .clk   (clk),
    .we    (word_done),
    .addr  (store_addr),
    .wdata (asm_next),
    .rdata (store_rdata)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD: begin
        if (boot_end || (word_done && (boot_addr == ADDR_MAX))) begin
          state_next = RUN;
        end
      end
      RUN:     state_next = RUN;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_cnt  <= '0;
      asm_word  <= '0;
      boot_addr <= '0;
    end else if (state == LOAD) begin
      if (boot_valid) begin
        asm_word <= asm_next;
        byte_cnt <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + BCW'(1);
      end
      if (word_done) begin
        boot_addr <= boot_addr + AW'(1);
      end
      // An early end drops any partially assembled word.
      if (boot_end) begin
        byte_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      opcode    <= RESET_OPCODE;
      uop_count <= '0;
      fault     <= 1'b0;
    end else if ((state == RUN) && !hold) begin
      if (ctrl[LOAD_OPCODE_BIT]) begin
        opcode <= ctrl[OPCODE_SRC_BIT] ? bus_opcode : opword_opcode;
      end
      if (ctrl[RESET_UOP_BIT]) begin
        uop_count <= '0;
      end else if (!ctrl[LOAD_OPCODE_BIT] && (uop_count == UOP_MAX)) begin
        fault     <= 1'b1;
        opcode    <= RESET_OPCODE;
        uop_count <= '0;
      end else begin
        uop_count <= uop_count + UOP_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_microcode_sequencer.sv
// +--------------------------------------------------------------------+
// | tb_microcode_sequencer                                             |
// | Directed self-checking bench for microcode_sequencer.              |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_microcode_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        hold;
  logic [5:0]  opword_opcode;
  logic [5:0]  bus_opcode;
  logic [31:0] ctrl;
  logic [5:0]  opcode;
  logic [4:0]  uop_count;
  logic        fault;
  logic [7:0]  boot_data;
  logic        boot_valid;
  logic        boot_end;
  logic [10:0] boot_addr;
  logic        n_booted;

  int errors = 0;
  int checks = 0;

  microcode_sequencer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .hold          (hold),
    .opword_opcode (opword_opcode),
    .bus_opcode    (bus_opcode),
    .ctrl          (ctrl),
    .opcode        (opcode),
    .uop_count     (uop_count),
    .fault         (fault),
    .boot_data     (boot_data),
    .boot_valid    (boot_valid),
    .boot_end      (boot_end),
    .boot_addr     (boot_addr),
    .n_booted      (n_booted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge; reset is released before the next edge.
  task automatic pulse_reset();
    n_rst = 1'b0;
    #2;
    check("rst_n_booted", 32'(n_booted), 32'd1);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_uop", 32'(uop_count), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_boot_addr", 32'(boot_addr), 32'd0);
    check("rst_ctrl", ctrl, 32'd0);
    n_rst = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    boot_valid = 1'b1;
    boot_data  = b;
    boot_end   = e;
    tick();
    boot_valid = 1'b0;
    boot_end   = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic end_last);
    for (int b = 3; b >= 0; b--) begin
      send_byte(w[8*b +: 8], end_last && (b == 0));
    end
  endtask

  task automatic end_boot();
    boot_end = 1'b1;
    tick();
    boot_end = 1'b0;
  endtask

  // Program: 0 -> load opcode from bus; {1,2} -> load from opword;
  // {3,3} -> load from opword and reset counter; opcode 5 words hold their index.
  function automatic logic [31:0] prog_c(input int a);
    if (a == 0)        return 32'h00C0_0000;
    else if (a == 34)  return 32'h0080_0000;
    else if (a == 99)  return 32'h0080_8000;
    else if (a >= 160) return 32'(a - 160);
    else               return 32'h0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst         = 1'b1;
    hold          = 1'b0;
    opword_opcode = 6'd3;
    bus_opcode    = 6'd1;
    boot_data     = 8'h00;
    boot_valid    = 1'b0;
    boot_end      = 1'b0;
    #1;
    pulse_reset();

    // Early end with nothing loaded.
    end_boot();
    check("a_n_booted", 32'(n_booted), 32'd0);
    check("a_opcode", 32'(opcode), 32'd0);
    check("a_uop", 32'(uop_count), 32'd0);
    check("a_boot_addr", 32'(boot_addr), 32'd0);

    // Single word with the counter-reset bit.
    pulse_reset();
    send_word(32'h0000_8000, 1'b0);
    check("b_boot_addr", 32'(boot_addr), 32'd1);
    check("b_n_booted_load", 32'(n_booted), 32'd1);
    check("b_ctrl_load", ctrl, 32'd0);
    end_boot();
    check("b_n_booted", 32'(n_booted), 32'd0);
    check("b_ctrl", ctrl, 32'h0000_8000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_uop_hold0", 32'(uop_count), 32'd0);
    end

    // Program load ending with BOOT_END on the last byte of word 191.
    pulse_reset();
    for (int a = 0; a < 192; a++) begin
      send_word(prog_c(a), a == 191);
    end
    check("c_n_booted", 32'(n_booted), 32'd0);
    check("c_boot_addr", 32'(boot_addr), 32'd192);
    check("c_ctrl0", ctrl, 32'h00C0_0000);
    tick();
    check("c_op_bus", 32'(opcode), 32'd1);
    check("c_uop1", 32'(uop_count), 32'd1);
    tick();
    check("c_ctrl_1_2", ctrl, 32'h0080_0000);
    tick();
    check("c_op_opword", 32'(opcode), 32'd3);
    check("c_uop3", 32'(uop_count), 32'd3);
    check("c_ctrl_3_3", ctrl, 32'h0080_8000);
    opword_opcode = 6'd5;
    tick();
    check("c_op_both", 32'(opcode), 32'd5);
    check("c_uop_both", 32'(uop_count), 32'd0);
    tick();
    tick();
    check("c_uop2", 32'(uop_count), 32'd2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c_hold_uop", 32'(uop_count), 32'd2);
      check("c_hold_ctrl", ctrl, 32'd2);
      check("c_hold_op", 32'(opcode), 32'd5);
    end
    hold = 1'b0;
    tick();
    check("c_resume_uop", 32'(uop_count), 32'd3);
    for (int k = 4; k < 32; k++) begin
      tick();
      check("c_count_uop", 32'(uop_count), 32'(k));
      check("c_count_ctrl", ctrl, 32'(k));
      check("c_count_fault", 32'(fault), 32'd0);
    end
    tick();
    check("c_fault", 32'(fault), 32'd1);
    check("c_fault_op", 32'(opcode), 32'd0);
    check("c_fault_uop", 32'(uop_count), 32'd0);
    tick();
    tick();
    check("c_fault_sticky", 32'(fault), 32'd1);
    check("c_op_after_fault", 32'(opcode), 32'd1);

    // Reset mid-RUN, then immediate BOOT_END keeps the store.
    pulse_reset();
    end_boot();
    check("c_store_kept", ctrl, 32'h00C0_0000);

    // Full 2048-word load.
    pulse_reset();
    for (int a = 0; a < 2047; a++) begin
      send_word(32'hA500_0000 | 32'(a), 1'b0);
    end
    check("d_addr_last", 32'(boot_addr), 32'd2047);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h07, 1'b0);
    check("d_n_booted_pre", 32'(n_booted), 32'd1);
    send_byte(8'hFF, 1'b0);
    check("d_n_booted", 32'(n_booted), 32'd0);
    check("d_boot_addr", 32'(boot_addr), 32'd0);
    check("d_ctrl0", ctrl, 32'hA500_0000);
    tick();
    check("d_ctrl1", ctrl, 32'hA500_0001);

    // Partial reload, reset after two bytes of word 7.
    pulse_reset();
    for (int a = 0; a < 7; a++) begin
      send_word(32'h5A00_0000 | 32'(a), 1'b0);
    end
    send_byte(8'h5A, 1'b0);
    send_byte(8'h00, 1'b0);
    pulse_reset();
    end_boot();
    for (int k = 0; k < 7; k++) begin
      check("e_new_word", ctrl, 32'h5A00_0000 | 32'(k));
      tick();
    end
    check("e_uop7", 32'(uop_count), 32'd7);
    check("e_word7_old", ctrl, 32'hA500_0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/microcode_sequencer.md
# microcode_sequencer

Parametrised successor to the fixed microcode ROM. It combines a writable control store, the opcode register and the micro-op counter in one block. After reset it loads the control store from a byte-serial bootstrap stream, then enters RUN. In RUN it steps through micro-ops, presents the current control word to the datapath each cycle, and handles opcode load, counter reset and runaway-sequence faults itself instead of leaving them to control logic.

## Interface
- OPCODE_W, 6, opcode width; control-store address high bits.
- UOP_W, 5, micro-op counter width; control-store address low bits.
- CTRL_W, 32, control word width; must be a multiple of 8.
- RESET_OPCODE, 0, opcode forced on entering RUN and on fault.
- RESET_UOP_BIT, 15, CTRL bit that resets the counter (misc plane).
- LOAD_OPCODE_BIT, 23, CTRL bit that loads the opcode register.
- OPCODE_SRC_BIT, 22, CTRL bit selecting the opcode source: 0 = OPWORD_OPCODE, 1 = BUS_OPCODE.
- CLK  in  1  clock; all state updates on its rising edge.
- N_RST  in  1  asynchronous, active-low reset.
- HOLD  in  1  stall; freezes the opcode register and the counter in RUN.
- OPWORD_OPCODE  in  OPCODE_W  opcode field of the opword register.
- BUS_OPCODE  in  OPCODE_W  low bits of the bus.
- CTRL  out  CTRL_W  current control word.
- OPCODE  out  OPCODE_W  opcode register.
- UOP_COUNT  out  UOP_W  micro-op counter.
- FAULT  out  1  sticky runaway-sequence flag.
- BOOT_DATA  in  8  bootstrap byte.
- BOOT_VALID  in  1  BOOT_DATA is accepted on this edge.
- BOOT_END  in  1  ends loading early.
- BOOT_ADDR  out  OPCODE_W+UOP_W  next control-store word to be written.
- N_BOOTED  out  1  high during LOAD, low in RUN.

## Operation
- States: LOAD and RUN. Reset enters LOAD.
- LOAD, byte assembly:
  - Each edge with BOOT_VALID shifts BOOT_DATA into the assembly register, MSB byte first.
  - After CTRL_W/8 bytes, the full word is written at BOOT_ADDR, BOOT_ADDR increments and the byte count clears.
- LOAD, exit to RUN:
  - On writing the last word (BOOT_ADDR at its maximum), BOOT_ADDR wraps to 0 and the state goes to RUN.
  - BOOT_END also goes to RUN. A partially assembled word is discarded.
  - If BOOT_VALID completes a word on the same edge as BOOT_END, the word is written first, then the state goes to RUN.
- LOAD, outputs and other inputs:
  - CTRL = 0, OPCODE = RESET_OPCODE, UOP_COUNT = 0.
  - HOLD is ignored.
- RUN, control word: CTRL = store[{OPCODE, UOP_COUNT}]. This is a combinational read of registered state, so CTRL changes only after edges.
- RUN, per edge with HOLD low, evaluated in this priority order:
  - CTRL[LOAD_OPCODE_BIT] set: OPCODE takes the source selected by CTRL[OPCODE_SRC_BIT].
  - CTRL[RESET_UOP_BIT] set: UOP_COUNT goes to 0. When both bits are set, both actions happen on the same edge.
  - Otherwise, if UOP_COUNT equals 2^UOP_W−1: FAULT is set, OPCODE goes to RESET_OPCODE and UOP_COUNT goes to 0 (runaway sequence).
  - Otherwise UOP_COUNT increments.
- FAULT clears only on N_RST.
- Boot-data inputs are ignored in RUN.
- Control store: 2^(OPCODE_W+UOP_W) × CTRL_W. Contents are undefined until loaded. Contents survive a reset that does not reload them only if BOOT_END is asserted immediately after reset.

## Timing
- Reset values (asynchronous, immediate): state LOAD, N_BOOTED = 1, OPCODE = RESET_OPCODE, UOP_COUNT = 0, FAULT = 0, BOOT_ADDR = 0, byte count 0, CTRL = 0.
- Bootstrap write: a word is committed on the edge that accepts its last byte. N_BOOTED falls on the edge that takes the state to RUN.
- Latency: CTRL is valid in the same cycle that OPCODE/UOP_COUNT update, with zero added latency.
- An opcode load takes effect at the next edge. The first micro-op of the new opcode is therefore presented one cycle after the load word.
- HOLD: while high, OPCODE, UOP_COUNT and CTRL are stable. The edge on which HOLD falls resumes normally.
- N_RST asserted mid-LOAD or mid-RUN aborts immediately. Any partial word is lost, and words already written remain in the store.

## Structure
- Package common holds:
  - the control-word field localparams (plane encodings, the bit positions used as defaults here), shared with control_logic;
  - the boot-state enum {LOAD, RUN}.
- Sub-module microcode_store: a single-port RAM with synchronous write and asynchronous read, parametrised on DEPTH and WIDTH. It is the only instance in the block.

## Test plan
- Reset, then BOOT_END without loading → N_BOOTED = 0 next edge, OPCODE = 0, UOP_COUNT = 0, BOOT_ADDR = 0.
- Load 4 bytes 0x00,0x00,0x80,0x00 → word 0 = 0x00008000 (RESET_UOP set), BOOT_ADDR = 1.
  - Then BOOT_END → in RUN, UOP_COUNT holds at 0 every cycle.
- Word at {1,2} with LOAD_OPCODE and OPCODE_SRC = 0, OPWORD_OPCODE = 3 → OPCODE = 3 and UOP_COUNT = 3 after that edge.
  - Same word with RESET_UOP also set → OPCODE = 3, UOP_COUNT = 0.
- Opcode 5 with all-zero words → UOP_COUNT counts 0..31, then at the 32nd edge FAULT = 1, OPCODE = 0, UOP_COUNT = 0. FAULT persists until N_RST.
- HOLD high 3 cycles at UOP_COUNT = 2 → UOP_COUNT and CTRL unchanged, then 3 on the first edge after HOLD falls.
- Full load of 2048 words → N_BOOTED falls on the last byte's edge and BOOT_ADDR = 0.
  - Mid-load N_RST after 2 bytes of word 7 → word 7 is not written, BOOT_ADDR = 0, N_BOOTED = 1.
